imem_boot_loader: RTL and testbench

- Boot sequencer for the RV32I core. Holds the core in reset and receives a program image as a byte stream over a valid/ready interface.
- Assembles little-endian 32-bit words, writes them to instruction memory from word 0 upward, and verifies a checksum.
- On success it releases the core; on any failure the core stays in reset.
- Sits between the external load port and the instruction memory write port, and drives the core's reset.

---
 rtl/imem_boot_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed, checksummed byte image, writes it to
// instruction memory as little-endian words and releases the core only on a good load.
// Revision 1.0

`default_nettype none

module imem_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [1:0]        byte_idx;
    logic [15:0]       word_cnt;
    logic [ADDR_W:0]   word_idx;
    logic [7:0]        csum;
    logic [23:0]       asm_lo;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   word_idx_inc;

    assign rx_ready     = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign accept       = rx_valid && rx_ready;
    assign len_full     = {rx_data, word_cnt[7:0]};
    assign word_idx_inc = word_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_nx = S_LEN;
                end
            end
            S_LEN: begin
                if (accept && byte_idx[0]) begin
                    if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN)) begin
                        state_nx = S_ERR;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (byte_idx == 2'd3)) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                // Compare the post-increment index so the last word goes straight to CSUM
                if (17'(word_idx_inc) == {1'b0, word_cnt}) begin
                    state_nx = S_CSUM;
                end else begin
                    state_nx = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_nx = (rx_data == csum) ? S_RUN : S_ERR;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx     <= 2'd0;
            word_cnt     <= 16'd0;
            word_idx     <= '0;
            csum         <= 8'd0;
            asm_lo       <= 24'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            core_reset_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            busy         <= (state_nx == S_LEN) || (state_nx == S_DATA) ||
                            (state_nx == S_WRITE) || (state_nx == S_CSUM);
            done         <= (state_nx == S_RUN);
            error        <= (state_nx == S_ERR);
            core_reset_n <= (state_nx == S_RUN);
            imem_we      <= (state_nx == S_WRITE);

            case (state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (start) begin
                        byte_idx <= 2'd0;
                        word_cnt <= 16'd0;
                        word_idx <= '0;
                        csum     <= 8'd0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (!byte_idx[0]) begin
                            word_cnt[7:0] <= rx_data;
                            byte_idx      <= 2'd1;
                        end else begin
                            word_cnt[15:8] <= rx_data;
                            byte_idx       <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum     <= csum + rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_lo[7:0]   <= rx_data;
                            2'd1: asm_lo[15:8]  <= rx_data;
                            2'd2: asm_lo[23:16] <= rx_data;
                            default: begin
                                imem_addr  <= word_idx[ADDR_W-1:0];
                                imem_wdata <= {rx_data, asm_lo};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench; stimulus queues expected writes/outcomes,
// a negedge monitor pops and compares them when the DUT writes or finishes a load.

`default_nettype none

module tb_imem_boot_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset_n;
    logic              busy;
    logic              done;
    logic              error;

    imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [ADDR_W+31:0] wq[$];   // {addr, data}
    logic [2:0]         oq[$];   // {done, error, core_reset_n}
    logic               term_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every write and every load outcome against the queues
    always @(negedge clk) begin
        logic [ADDR_W+31:0] we;
        logic [2:0]         oe;
        if (reset) begin
            if (imem_we) begin
                check("rx_ready_in_write", 32'(rx_ready), 32'd0);
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    we = wq.pop_front();
                    check("write_addr", 32'(imem_addr), 32'(we[ADDR_W+31:32]));
                    check("write_data", imem_wdata, we[31:0]);
                end
            end
            if ((done || error) && !term_prev) begin
                if (oq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_outcome: got done=%b error=%b expected none", done, error);
                end else begin
                    oe = oq.pop_front();
                    check("outcome", {29'd0, done, error, core_reset_n}, {29'd0, oe});
                end
            end
        end
        term_prev = done || error;
    end

    task automatic send_byte(input logic [7:0] b, input bit thr);
        int n;
        int t;
        bit got;
        if (thr) begin
            rx_valid = 1'b0;
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        got = 1'b0;
        t = 0;
        while (!got && t < 64) begin
            @(negedge clk);
            got = rx_ready;
            t++;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL byte_accept_timeout: got rx_ready=0 expected 1 within 64 cycles");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_image(input logic [31:0] w[$], input bit bad, input bit thr);
        logic [15:0] n;
        logic [7:0]  ck;
        logic [7:0]  b;
        n  = 16'(w.size());
        ck = 8'd0;
        send_byte(n[7:0], thr);
        send_byte(n[15:8], thr);
        for (int i = 0; i < w.size(); i++) begin
            wq.push_back({ADDR_W'(i), w[i]});
            for (int k = 0; k < 4; k++) begin
                b  = w[i][8*k +: 8];
                ck = ck + b;
                send_byte(b, thr);
            end
        end
        oq.push_back(bad ? 3'b010 : 3'b101);
        send_byte(bad ? ck + 8'd1 : ck, thr);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},     32'(rx_ready),     32'd0);
        check({tag, "_imem_we"},      32'(imem_we),      32'd0);
        check({tag, "_imem_addr"},    32'(imem_addr),    32'd0);
        check({tag, "_imem_wdata"},   imem_wdata,        32'd0);
        check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_done"},         32'(done),         32'd0);
        check({tag, "_error"},        32'(error),        32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] basic[$];
        logic [31:0] one[$];
        logic [31:0] big[$];

        basic.push_back(32'h0010_0013);
        basic.push_back(32'h0020_0093);
        one.push_back(32'hDEAD_BEEF);
        for (int i = 0; i < MAX_WORDS; i++) big.push_back(32'(i));

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic load
        pulse_start();
        send_image(basic, 1'b0, 1'b0);

        // Bad checksum, started from RUN
        pulse_start();
        send_image(basic, 1'b1, 1'b0);

        // Zero length and over-length, each started from ERR
        pulse_start();
        oq.push_back(3'b010);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        pulse_start();
        oq.push_back(3'b010);
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Throttled basic load
        pulse_start();
        send_image(basic, 1'b0, 1'b1);

        // Reload from RUN: core drops out of reset-release on the next cycle
        pulse_start();
        check("reload_core_reset_n", 32'(core_reset_n), 32'd0);
        check("reload_done",         32'(done),         32'd0);
        check("reload_busy",         32'(busy),         32'd1);
        send_image(one, 1'b0, 1'b0);

        // Abort with reset after the second payload byte
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        reset = 1'b0;
        #2;
        check_reset_values("abort");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Maximum-size image with stray start pulses during the load
        pulse_start();
        fork
            send_image(big, 1'b0, 1'b0);
            begin
                repeat (3) begin
                    repeat (1500) @(posedge clk);
                    #1;
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        join
        check("max_done",         32'(done),         32'd1);
        check("max_core_reset_n", 32'(core_reset_n), 32'd1);

        check("writes_drained",   32'(wq.size()), 32'd0);
        check("outcomes_drained", 32'(oq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
